// File: rtl/tx_uart_drain.sv
// Drains 32-bit words from a registered-read TX FIFO and sends each one as four
// UART 8N1 frames on txd, least significant byte first.
module tx_uart_drain #(
   parameter int CLKS_PER_BIT = 868,
   parameter int RD_LATENCY   = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        fifo_empty,
   input  logic [31:0] fifo_dout,
   output logic        fifo_re,
   output logic        txd,
   output logic        busy
);

   localparam int BAUD_W = $clog2(CLKS_PER_BIT);
   localparam int CAP_W  = $clog2(RD_LATENCY + 1);

   localparam logic [BAUD_W-1:0] BAUD_RELOAD   = BAUD_W'(CLKS_PER_BIT - 1);
   localparam logic [CAP_W-1:0]  CAP_LOAD      = CAP_W'(RD_LATENCY);
   localparam logic [CAP_W-1:0]  CAP_LAST_WAIT = CAP_W'(2);
   localparam logic [CAP_W-1:0]  CAP_FIRE      = CAP_W'(1);

   localparam logic [2:0] IDLE  = 3'd0;
   localparam logic [2:0] REQ   = 3'd1;
   localparam logic [2:0] WAIT  = 3'd2;
   localparam logic [2:0] START = 3'd3;
   localparam logic [2:0] DATA  = 3'd4;
   localparam logic [2:0] STOP  = 3'd5;

   logic [2:0]        state;
   logic [BAUD_W-1:0] baud;
   logic [CAP_W-1:0]  cap_cnt;
   logic [1:0]        byte_idx;
   logic [2:0]        bit_idx;
   logic [2:0]        bit_nxt;
   logic [31:0]       shift_word;
   logic              cap_en;

   assign bit_nxt = bit_idx + 3'd1;

   // The read data lands one edge into the start bit; the start bit level does
   // not depend on it, which is why CLKS_PER_BIT must be at least 2.
   assign cap_en = (cap_cnt == CAP_FIRE);

   always_ff @(posedge clk) begin
      if (cap_en) shift_word <= fifo_dout;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         txd      <= 1'b1;
         fifo_re  <= 1'b0;
         busy     <= 1'b0;
         baud     <= '0;
         cap_cnt  <= '0;
         byte_idx <= '0;
         bit_idx  <= '0;
      end else begin
         fifo_re <= 1'b0;
         if (cap_cnt != '0) cap_cnt <= cap_cnt - CAP_W'(1);
         if (baud != '0) baud <= baud - BAUD_W'(1);

         case (state)
            IDLE: begin
               txd <= 1'b1;
               if (!fifo_empty) begin
                  state   <= REQ;
                  fifo_re <= 1'b1;
                  busy    <= 1'b1;
               end
            end
            REQ: begin
               cap_cnt  <= CAP_LOAD;
               byte_idx <= '0;
               if (RD_LATENCY == 1) begin
                  state <= START;
                  txd   <= 1'b0;
                  baud  <= BAUD_RELOAD;
               end else begin
                  state <= WAIT;
               end
            end
            WAIT: begin
               if (cap_cnt == CAP_LAST_WAIT) begin
                  state <= START;
                  txd   <= 1'b0;
                  baud  <= BAUD_RELOAD;
               end
            end
            START: begin
               if (baud == '0) begin
                  state   <= DATA;
                  bit_idx <= '0;
                  txd     <= shift_word[{byte_idx, 3'd0}];
                  baud    <= BAUD_RELOAD;
               end
            end
            DATA: begin
               if (baud == '0) begin
                  baud <= BAUD_RELOAD;
                  if (bit_idx == 3'd7) begin
                     state <= STOP;
                     txd   <= 1'b1;
                  end else begin
                     bit_idx <= bit_nxt;
                     txd     <= shift_word[{byte_idx, bit_nxt}];
                  end
               end
            end
            STOP: begin
               if (baud == '0) begin
                  if (byte_idx != 2'd3) begin
                     byte_idx <= byte_idx + 2'd1;
                     state    <= START;
                     txd      <= 1'b0;
                     baud     <= BAUD_RELOAD;
                  end else begin
                     state <= IDLE;
                     busy  <= 1'b0;
                  end
               end
            end
            default: begin
               state <= IDLE;
               txd   <= 1'b1;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_tx_uart_drain.sv
// Bench for tx_uart_drain: two instances (RD_LATENCY 2 and 1) fed by small
// behavioural FIFOs; a UART frame monitor checks bytes against a scoreboard.
module tb_tx_uart_drain;

   logic        clk = 1'b0;
   logic [1:0]  rst_n_w = 2'b00;
   logic [1:0]  empty_w;
   logic [1:0]  re_w;
   logic [1:0]  txd_w;
   logic [1:0]  busy_w;
   logic [31:0] dout0 = '0;
   logic [31:0] dout1;
   logic [31:0] p1_0 = '0;
   logic [31:0] p1_1 = '0;
   logic [31:0] fmem0 [16];
   logic [31:0] fmem1 [16];
   logic [3:0]  wp0 = '0, rp0 = '0, wp1 = '0, rp1 = '0;
   logic        force_ne = 1'b0;

   logic [7:0]  exp0 [$];
   logic [7:0]  exp1 [$];

   int cyc = 0;
   int total = 0;
   int bad = 0;
   int re_cnt [2] = '{0, 0};
   int re_last [2] = '{0, 0};
   int re_prev [2] = '{0, 0};
   int busy_rise [2] = '{0, 0};
   int busy_len [2] = '{0, 0};
   logic busy_d [2] = '{1'b0, 1'b0};
   int word_gap [2] = '{0, 0};
   int word_lat [2] = '{0, 0};

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   tx_uart_drain #(.CLKS_PER_BIT(4), .RD_LATENCY(2)) u_dut0 (
      .clk(clk), .rst_n(rst_n_w[0]), .fifo_empty(empty_w[0]), .fifo_dout(dout0),
      .fifo_re(re_w[0]), .txd(txd_w[0]), .busy(busy_w[0]));

   tx_uart_drain #(.CLKS_PER_BIT(4), .RD_LATENCY(1)) u_dut1 (
      .clk(clk), .rst_n(rst_n_w[1]), .fifo_empty(empty_w[1]), .fifo_dout(dout1),
      .fifo_re(re_w[1]), .txd(txd_w[1]), .busy(busy_w[1]));

   // FIFO models: one extra output register gives the latency-2 read port
   assign empty_w[0] = ~force_ne & (wp0 == rp0);
   assign empty_w[1] = (wp1 == rp1);
   assign dout1 = p1_1;

   always @(posedge clk) begin
      if (re_w[0] && (wp0 != rp0)) begin
         p1_0 <= fmem0[rp0];
         rp0  <= rp0 + 4'd1;
      end
      dout0 <= p1_0;
      if (re_w[1] && (wp1 != rp1)) begin
         p1_1 <= fmem1[rp1];
         rp1  <= rp1 + 4'd1;
      end
   end

   always @(negedge clk) begin
      for (int g = 0; g < 2; g++) begin
         if (re_w[g]) begin
            re_cnt[g]  <= re_cnt[g] + 1;
            re_prev[g] <= re_last[g];
            re_last[g] <= cyc;
         end
         if (busy_w[g] && !busy_d[g]) busy_rise[g] <= cyc;
         if (!busy_w[g] && busy_d[g]) busy_len[g] <= cyc - busy_rise[g];
         busy_d[g] <= busy_w[g];
      end
   end

   function automatic void chk(input string name, input int act, input int req);
      total++;
      if (act != req) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
      end
   endfunction

   function automatic bit pop_exp(input int g, output logic [7:0] b);
      b = 8'h00;
      if (g == 0 && exp0.size() != 0) begin b = exp0.pop_front(); return 1'b1; end
      if (g == 1 && exp1.size() != 0) begin b = exp1.pop_front(); return 1'b1; end
      return 1'b0;
   endfunction

   function automatic int exp_size(input int g);
      return (g == 0) ? exp0.size() : exp1.size();
   endfunction

   task automatic push_word(input int g, input logic [31:0] w);
      if (g == 0) begin
         fmem0[wp0] = w;
         wp0 = wp0 + 4'd1;
         for (int b = 0; b < 4; b++) exp0.push_back(w[8*b +: 8]);
      end else begin
         fmem1[wp1] = w;
         wp1 = wp1 + 4'd1;
         for (int b = 0; b < 4; b++) exp1.push_back(w[8*b +: 8]);
      end
   endtask

   // Monitor: decodes every frame cycle by cycle and scores it against the queue
   task automatic frame_mon(input int g);
      logic       prev;
      logic [7:0] eb, got;
      logic       lvl;
      int         start, prev_end, mism, k;
      bit         have, aborted;
      prev = 1'b1;
      prev_end = 0;
      forever begin
         @(negedge clk);
         if (rst_n_w[g] && prev && !txd_w[g]) begin
            start = cyc;
            if (start != prev_end) begin
               word_gap[g] = start - prev_end;
               word_lat[g] = start - re_last[g];
            end
            have = pop_exp(g, eb);
            mism = 0;
            got = 8'h00;
            aborted = 1'b0;
            for (int j = 0; j < 40; j++) begin
               if (j > 0) @(negedge clk);
               if (!rst_n_w[g]) begin
                  aborted = 1'b1;
                  break;
               end
               k = j / 4;
               lvl = (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : eb[k-1];
               if (txd_w[g] !== lvl) mism++;
               if ((j % 4) == 2 && k >= 1 && k <= 8) got[k-1] = txd_w[g];
            end
            if (aborted) begin
               prev_end = 0;
            end else begin
               chk($sformatf("frame_expected[%0d]", g), int'(have), 1);
               if (have) begin
                  chk($sformatf("rx_byte[%0d]", g), int'(got), int'(eb));
                  chk($sformatf("frame_shape[%0d]", g), mism, 0);
               end
               prev_end = start + 40;
            end
         end
         prev = txd_w[g];
      end
   endtask

   initial frame_mon(0);
   initial frame_mon(1);

   task automatic wait_re(input int g, input int base, input string name);
      int i;
      i = 0;
      while (i < 30 && re_cnt[g] == base) begin
         @(negedge clk);
         i++;
      end
      chk(name, int'(re_cnt[g] != base), 1);
   endtask

   task automatic wait_drain(input int g, input int budget, input string name);
      int i;
      i = 0;
      while (i < budget && !(empty_w[g] && !busy_w[g] && exp_size(g) == 0)) begin
         @(negedge clk);
         i++;
      end
      chk(name, int'(i < budget), 1);
      repeat (5) @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int base, r, idle_bad;

      // Reset state and idle with an empty FIFO
      repeat (3) @(negedge clk);
      chk("reset_txd", int'(txd_w[0]), 1);
      chk("reset_busy", int'(busy_w[0]), 0);
      chk("reset_re", int'(re_w[0]), 0);
      rst_n_w = 2'b11;
      idle_bad = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (txd_w[0] !== 1'b1 || re_w[0] !== 1'b0 || busy_w[0] !== 1'b0) idle_bad++;
      end
      chk("idle_hold", idle_bad, 0);

      // Single word
      base = re_cnt[0];
      push_word(0, 32'hA5C3_0F81);
      wait_drain(0, 400, "word1_drain");
      chk("word1_re_pulses", re_cnt[0] - base, 1);
      chk("word1_busy_len", busy_len[0], 162);
      chk("word1_start_lat", word_lat[0], 2);

      // Back-to-back words
      base = re_cnt[0];
      push_word(0, 32'h1111_1111);
      push_word(0, 32'h2222_2222);
      wait_drain(0, 600, "b2b_drain");
      chk("b2b_re_pulses", re_cnt[0] - base, 2);
      chk("b2b_re_spacing", re_last[0] - re_prev[0], 163);
      chk("b2b_gap", word_gap[0], 3);

      // Asynchronous reset during the start bit of byte 2
      base = re_cnt[0];
      push_word(0, 32'hFFFF_0000);
      wait_re(0, base, "rst_word_re");
      r = re_last[0];
      while (cyc < r + 83) @(negedge clk);
      chk("pre_reset_txd", int'(txd_w[0]), 0);
      #2 rst_n_w[0] = 1'b0;
      #1;
      chk("async_reset_txd", int'(txd_w[0]), 1);
      chk("async_reset_busy", int'(busy_w[0]), 0);
      repeat (3) @(negedge clk);
      rst_n_w[0] = 1'b1;
      exp0.delete();
      repeat (60) @(negedge clk);
      chk("post_reset_re", re_cnt[0] - base, 1);
      chk("post_reset_busy", int'(busy_w[0]), 0);
      chk("post_reset_txd", int'(txd_w[0]), 1);

      // fifo_empty toggling while busy
      base = re_cnt[0];
      push_word(0, 32'h0000_0000);
      wait_re(0, base, "toggle_word_re");
      r = re_last[0];
      while (cyc < r + 10) @(negedge clk);
      for (int i = 0; i < 130; i++) begin
         force_ne = ~force_ne;
         @(negedge clk);
      end
      force_ne = 1'b0;
      wait_drain(0, 400, "toggle_drain");
      repeat (20) @(negedge clk);
      chk("toggle_re_pulses", re_cnt[0] - base, 1);
      chk("toggle_busy_len", busy_len[0], 162);

      // Latency-1 instance
      base = re_cnt[1];
      push_word(1, 32'hA5C3_0F81);
      push_word(1, 32'h5A3C_F07E);
      wait_drain(1, 600, "lat1_drain");
      chk("lat1_re_pulses", re_cnt[1] - base, 2);
      chk("lat1_re_spacing", re_last[1] - re_prev[1], 162);
      chk("lat1_gap", word_gap[1], 2);
      chk("lat1_start_lat", word_lat[1], 1);
      chk("lat1_busy_len", busy_len[1], 161);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
